// File: rtl/sram_resp_ctrl.sv
// sram_resp_ctrl: turns one 32-bit LSU load/store into one or two 16-bit async SRAM accesses, then acks.
// Optional SRAM_RD_SKIP_EN: reads honour i_bmask and skip halves whose mask bits are zero.
module sram_resp_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    input  logic        i_wren,
    input  logic        i_rden,
    output logic [31:0] o_ld_data,
    output logic        o_ack,
    output logic [17:0] o_sram_addr,
    inout  wire  [15:0] io_sram_dq,
    output logic        o_sram_ce_n,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_lb_n,
    output logic        o_sram_ub_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LP_W = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:0] r_data;
    logic [16:0] r_addr;
    logic [31:0] r_rd_buf;
    logic [17:0] r_sram_addr;
    logic        r_ack, r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n, r_dq_oe;
    logic [15:0] r_dq_out;

    state_t      w_nx_state;
    logic [3:0]  w_nx_cnt;
    logic        w_nx_wr;
    logic [3:0]  w_nx_mask;
    logic [31:0] w_nx_data;
    logic [16:0] w_nx_addr;
    logic [3:0]  w_req_mask;
    logic        w_last, w_nx_ph, w_nx_hi;
    logic [1:0]  w_nx_hm;
    logic        w_unused;

    // Without the skip feature a read always touches both halves.
`ifdef SRAM_RD_SKIP_EN
    assign w_req_mask = i_bmask;
`else
    assign w_req_mask = i_wren ? i_bmask : 4'hF;
`endif

    assign w_unused = ^{i_req_addr[31:19], i_req_addr[1:0]};
    assign w_last   = r_cnt == LP_W;

    always_comb begin
        w_nx_state = r_state;
        w_nx_wr    = r_wr;
        w_nx_mask  = r_mask;
        w_nx_data  = r_data;
        w_nx_addr  = r_addr;
        w_nx_cnt   = (r_state == LO || r_state == HI) && !w_last ? r_cnt + 4'd1 : 4'd0;
        case (r_state)
            IDLE: if (i_wren || i_rden) begin
                w_nx_wr    = i_wren;
                w_nx_mask  = w_req_mask;
                w_nx_data  = i_st_data;
                w_nx_addr  = i_req_addr[18:2];
                w_nx_state = |w_req_mask[1:0] ? LO : |w_req_mask[3:2] ? HI : DONE;
            end
            LO:      if (w_last) w_nx_state = |r_mask[3:2] ? HI : DONE;
            HI:      if (w_last) w_nx_state = DONE;
            default: w_nx_state = IDLE;
        endcase
    end

    assign w_nx_ph = w_nx_state == LO || w_nx_state == HI;
    assign w_nx_hi = w_nx_state == HI;
    assign w_nx_hm = w_nx_hi ? w_nx_mask[3:2] : w_nx_mask[1:0];

    // Bus outputs are registered from the next state so each phase sees them from its first cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_mask      <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_rd_buf    <= '0;
            r_sram_addr <= '0;
            r_ack       <= 1'b0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            r_state  <= w_nx_state;
            r_cnt    <= w_nx_cnt;
            r_wr     <= w_nx_wr;
            r_mask   <= w_nx_mask;
            r_data   <= w_nx_data;
            r_addr   <= w_nx_addr;
            r_ack    <= w_nx_state == DONE;
            r_ce_n   <= !w_nx_ph;
            r_we_n   <= !(w_nx_ph && w_nx_wr && w_nx_cnt != LP_W);
            r_oe_n   <= !(w_nx_ph && !w_nx_wr);
            r_lb_n   <= w_nx_ph ? w_nx_wr && !w_nx_hm[0] : 1'b1;
            r_ub_n   <= w_nx_ph ? w_nx_wr && !w_nx_hm[1] : 1'b1;
            r_dq_oe  <= w_nx_ph && w_nx_wr;
            r_dq_out <= w_nx_hi ? w_nx_data[31:16] : w_nx_data[15:0];
            if (w_nx_ph)
                r_sram_addr <= {w_nx_addr, w_nx_hi};
            if (r_state == IDLE && i_rden && !i_wren)
                r_rd_buf <= '0;
            else if (r_state == LO && w_last && !r_wr)
                r_rd_buf[15:0] <= io_sram_dq;
            else if (r_state == HI && w_last && !r_wr)
                r_rd_buf[31:16] <= io_sram_dq;
        end
    end

    assign io_sram_dq  = r_dq_oe ? r_dq_out : 16'hzzzz;
    assign o_ld_data   = r_rd_buf;
    assign o_ack       = r_ack;
    assign o_sram_addr = r_sram_addr;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_we_n = r_we_n;
    assign o_sram_oe_n = r_oe_n;
    assign o_sram_lb_n = r_lb_n;
    assign o_sram_ub_n = r_ub_n;
endmodule

// File: doc/sram_resp_ctrl.md
Name: sram_resp_ctrl

Overview:
Responder for the LSU's memory request/ack handshake. It converts one 32-bit load or store from the pipeline's MEM stage into one or two 16-bit accesses on an external asynchronous SRAM (18-bit halfword address, active-low controls). It returns a one-cycle o_ack on completion. The core holds the MEM stage stalled while a request is pending and o_ack is low.

Parameters:
- WAIT_CYCLES, 1: cycles the SRAM is held per halfword phase before the hold cycle. Legal values are 1..15.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, asynchronous and active-high.
- i_req_addr, in, 32: byte address. Word index is i_req_addr[18:2]; bits [1:0] are ignored.
- i_st_data, in, 32: store data.
- i_bmask, in, 4: byte enables. Bit n enables byte n.
- i_wren, in, 1: store request.
- i_rden, in, 1: load request.
- o_ld_data, out, 32: load data. Valid while o_ack=1.
- o_ack, out, 1: completion pulse, high for one cycle.
- o_sram_addr, out, 18: halfword address.
- io_sram_dq, inout, 16: SRAM data bus.
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, out, 1 each: active-low SRAM controls.

Behaviour:
- Clock and reset: one clock domain, i_clk. i_rst is asynchronous and active-high.
- Reset values: FSM goes to IDLE; o_ack=0; o_ld_data=0; o_sram_addr=0; all *_n outputs=1; io_sram_dq tri-stated. An assertion of i_rst during any phase aborts the transaction immediately and no ack is issued.
- FSM states are IDLE, LO, HI, DONE.
- IDLE:
  - Samples the request each cycle.
  - i_wren has priority if both i_wren and i_rden are set.
  - On write, latches addr, data and mask, then goes to:
    - LO if mask[1:0] is nonzero;
    - else HI if mask[3:2] is nonzero;
    - else DONE.
  - On read, latches addr and goes to LO.
  - No request: stays in IDLE.
- LO and HI phases:
  - Each phase lasts WAIT_CYCLES+1 cycles, counted by a phase counter that resets on phase entry.
  - o_sram_addr = {word_idx, 0} in LO and {word_idx, 1} in HI.
  - ce_n=0 for the whole phase.
- Write phase:
  - dq is driven with the latched half (LO takes [15:0], HI takes [31:16]) for the whole phase.
  - we_n=0 for the first WAIT_CYCLES cycles and 1 in the final cycle, so address and data hold past the we_n rise.
  - lb_n/ub_n are the inverted mask bits of that half.
  - oe_n=1.
- Read phase:
  - oe_n=0 and we_n=1; lb_n=ub_n=0.
  - dq is tri-stated.
  - dq is captured at the clock edge ending the phase's final cycle, into the matching half of the read buffer.
- Transitions out of LO: for writes, go to HI if mask[3:2] is nonzero, else DONE. For reads, always go to HI. HI always goes to DONE.
- DONE:
  - One cycle: o_ack=1 and o_ld_data = read buffer.
  - For stores, o_ld_data holds the last read value and is don't-care to the LSU.
  - SRAM controls are idle and dq is tri-stated.
  - Next state is IDLE.
  - A request present during DONE is ignored; it is sampled in the following IDLE cycle.
- Idle bus outside phases: all *_n=1, dq tri-stated, and o_sram_addr holds its last value.
- Latency with W=WAIT_CYCLES, counting from a request first seen in IDLE at cycle t:
  - Full access: o_ack in cycle t+1+2(W+1).
  - Single-half write: o_ack in cycle t+1+(W+1).
  - Zero-mask write: o_ack in cycle t+1.
- Bus contention: dq is never driven in the same cycle as oe_n=0.
- Request stability: the requester keeps the request stable until ack. The controller ignores input changes after latching.

Optional Feature:
SRAM_RD_SKIP_EN
- When defined, reads honour i_bmask the same way writes do:
  - a half with zero mask is skipped, and that half of o_ld_data returns 0;
  - a zero-mask read goes straight to DONE with o_ld_data=0.
- When undefined, reads ignore i_bmask and always access both halves.

Test Plan:
- Reset mid-phase: assert i_rst during LO of a write. Expect outputs to return to reset values asynchronously and no ack. The next read from the same address returns the old contents.
- Full word round trip, WAIT_CYCLES=1:
  - Store 0xDEADBEEF to 0x00000100 with mask 4'hF, request seen at t. Expect two writes: addr 0x00080 with 0xBEEF, then 0x00081 with 0xDEAD. Expect o_ack at t+5.
  - Load the same address. Expect o_ld_data=0xDEADBEEF with o_ack at t+5.
- Byte store: store 0x000000AA to 0x100 with mask 4'h1. Expect only the LO phase with lb_n=0, ub_n=1, and ack at t+3. A following load returns 0xDEADBEAA.
- Upper halfword store: mask 4'hC with data 0x12340000. Expect the HI phase only at addr 0x00081, then ack. A following load returns 0x1234BEAA.
- Zero-mask store, and i_wren with i_rden together:
  - Zero-mask store: ack at t+1 with no SRAM activity.
  - i_wren=i_rden=1: performs a write.
- Macro on: load with mask 4'h3 from a word holding 0x1234BEAA. Expect the LO phase only and o_ld_data=0x0000BEAA at t+3. Macro off: the same load returns 0x1234BEAA at t+5.
